// File: rtl/ntt_pair_sched_if.sv
// rtl/ntt_pair_sched_if.sv - pair-issue bus between the NTT pair scheduler and the coefficient read port
interface ntt_pair_sched_if #(
  parameter int ADDR_W  = 8,
  parameter int ZIDX_W  = 8,
  parameter int STAGE_W = 4
);

  logic               valid_o;
  logic               ready_i;
  logic [ADDR_W-1:0]  addr_u_o;
  logic [ADDR_W-1:0]  addr_t_o;
  logic [ZIDX_W-1:0]  zeta_idx_o;
  logic [STAGE_W-1:0] stage_o;
  logic               ct_o;
  logic               last_o;

  modport master (
    output valid_o, addr_u_o, addr_t_o, zeta_idx_o, stage_o, ct_o, last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, addr_u_o, addr_t_o, zeta_idx_o, stage_o, ct_o, last_o,
    output ready_i
  );

endinterface

// File: rtl/ntt_pair_sched.sv
// rtl/ntt_pair_sched.sv - butterfly pair/twiddle scheduler for CT forward and GS inverse NTT; optional NTT_PAIR_SCHED_STALL_CNT_EN adds a stall counter
module ntt_pair_sched #(
  parameter int N          = 256,
  parameter int MIN_LEN    = 1,
  parameter int BU_LATENCY = 4,
  parameter int ADDR_W     = $clog2(N),
  parameter int ZIDX_W     = $clog2(N / MIN_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_ct_i,
  ntt_pair_sched_if.master pair,
  output logic             busy_o,
  output logic             done_o
`ifdef NTT_PAIR_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  localparam int STAGE_W = $clog2(ZIDX_W + 1);
  // One extra bit so base can reach N and len can overshoot after the final stage.
  localparam int LW      = ADDR_W + 1;
  localparam int DW      = (BU_LATENCY > 0) ? $clog2(BU_LATENCY + 1) : 1;

  localparam logic [LW-1:0]      N_L        = LW'(N);
  localparam logic [LW-1:0]      HALF_L     = LW'(N / 2);
  localparam logic [LW-1:0]      MIN_L      = LW'(MIN_LEN);
  localparam logic [ZIDX_W-1:0]  K_CT0      = ZIDX_W'(1);
  localparam logic [ZIDX_W-1:0]  K_GS0      = ZIDX_W'(N / MIN_LEN - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(ZIDX_W - 1);
  localparam logic [STAGE_W-1:0] NUM_STAGES = STAGE_W'(ZIDX_W);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'((BU_LATENCY > 0) ? BU_LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                ct_q, ct_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       base_q, base_d;
  logic [LW-1:0]       j_q, j_d;
  logic [ZIDX_W-1:0]   k_q, k_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [DW-1:0]       drain_q, drain_d;

  logic [LW-1:0]       j_inc;
  logic [LW-1:0]       base_inc;
  logic                group_end;
  logic                stage_end;

  assign j_inc     = j_q + LW'(1);
  assign base_inc  = base_q + (len_q << 1);
  assign group_end = (j_inc == len_q);
  assign stage_end = group_end && (base_inc == N_L);

  // State and loop counters; everything clears on reset so outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ct_q    <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      len_q   <= len_d;
      base_q  <= base_d;
      j_q     <= j_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  // Next-state: walk j within a group, groups within a stage, then drain and move on.
  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    len_d   = len_q;
    base_d  = base_q;
    j_d     = j_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ct_d    = mode_ct_i;
          len_d   = mode_ct_i ? HALF_L : MIN_L;
          k_d     = mode_ct_i ? K_CT0 : K_GS0;
          base_d  = '0;
          j_d     = '0;
          stage_d = '0;
          drain_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (pair.ready_i) begin
          if (group_end) begin
            j_d = '0;
            k_d = ct_q ? (k_q + ZIDX_W'(1)) : (k_q - ZIDX_W'(1));
            if (stage_end) begin
              base_d  = '0;
              len_d   = ct_q ? (len_q >> 1) : (len_q << 1);
              stage_d = stage_q + STAGE_W'(1);
              drain_d = '0;
              if (BU_LATENCY > 0) begin
                state_d = S_DRAIN;
              end else if (stage_q == LAST_STAGE) begin
                state_d = S_DONE;
              end else begin
                state_d = S_RUN;
              end
            end else begin
              base_d = base_inc;
            end
          end else begin
            j_d = j_inc;
          end
        end
      end
      S_DRAIN: begin
        // stage_q already names the upcoming stage, so NUM_STAGES means all are done.
        if (drain_q == DRAIN_LAST) begin
          state_d = (stage_q == NUM_STAGES) ? S_DONE : S_RUN;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pair.valid_o    = (state_q == S_RUN);
  assign pair.addr_u_o   = ADDR_W'(base_q + j_q);
  assign pair.addr_t_o   = ADDR_W'(base_q + j_q + len_q);
  assign pair.zeta_idx_o = k_q;
  assign pair.stage_o    = stage_q;
  assign pair.ct_o       = ct_q;
  assign pair.last_o     = (state_q == S_RUN) && (stage_q == LAST_STAGE) && stage_end;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);

`ifdef NTT_PAIR_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count back-pressured issue cycles of the current transform, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && !pair.ready_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/ntt_pair_sched.md
Name: ntt_pair_sched

Overview:
- Upstream scheduler for the butterfly unit.
- For one full NTT (Cooley-Tukey, forward) or inverse NTT (Gentleman-Sande), it emits the sequence of coefficient-pair read addresses (u, t) and the twiddle-ROM index.
- Handshakes each pair to the coefficient-memory read port that feeds the butterfly.
- Inserts a pipeline-drain gap between stages so no read overtakes a pending butterfly write-back (RAW hazard).

Parameters:
- N, 256, transform length; power of two, >=4.
- MIN_LEN, 1, smallest butterfly span; power of two, <N/2 (1 = full NTT, 2 = Kyber-style).
- BU_LATENCY, 4, cycles from pair issue to write-back; 0 disables the drain gap.
- ADDR_W, $clog2(N), coefficient address width.
- ZIDX_W, $clog2(N/MIN_LEN), twiddle index width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a transform; sampled only in IDLE.
- mode_ct_i  in  1  1 = CT forward ordering, 0 = GS inverse ordering; latched with start_i.
- ready_i  in  1  downstream accepts the current pair.
- valid_o  out  1  addr_u_o/addr_t_o/zeta_idx_o valid.
- addr_u_o  out  ADDR_W  address of u operand.
- addr_t_o  out  ADDR_W  address of t operand (= addr_u_o + len).
- zeta_idx_o  out  ZIDX_W  twiddle ROM index.
- stage_o  out  $clog2(ZIDX_W+1)  current stage number, 0-based.
- ct_o  out  1  latched mode, forwarded to the butterfly CT_nGS input.
- last_o  out  1  current pair is the final pair of the transform.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the transform is complete.

Behaviour:
- Reset (rst_i=1 at an edge, any state):
  - state=IDLE; all outputs 0; counters cleared.
  - A reset mid-transform abandons it with no done_o.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches mode_ct_i.
  - Initialises counters:
    - CT: len=N/2, k=1.
    - GS: len=MIN_LEN, k=N/MIN_LEN-1.
  - Sets base=0, j=0; next state RUN.
- RUN:
  - valid_o=1 (registered; first valid in the cycle after start is sampled).
  - addr_u_o=base+j, addr_t_o=base+j+len, zeta_idx_o=k.
  - Outputs hold stable while ready_i=0; nothing changes without a handshake (valid_o&ready_i).
  - On handshake:
    - j++.
    - If j reaches len: j=0, base+=2*len, and k advances (CT +1, GS -1).
    - If base reaches N, the stage ends.
- Stage end:
  - CT: len halves; GS: len doubles.
  - Next state:
    - DRAIN if BU_LATENCY>0.
    - Otherwise RUN for the next stage, or DONE after the final stage.
- Number of stages: log2(N/MIN_LEN). Final stage is len=MIN_LEN (CT) or len=N/2 (GS).
- DRAIN:
  - valid_o=0 for exactly BU_LATENCY cycles.
  - Then RUN (next stage) or DONE (after the final stage).
  - ready_i is ignored.
- DONE: done_o=1 for one cycle, busy_o=1; then IDLE.
- Per transform: N/2 pairs per stage, N/MIN_LEN-1 distinct twiddle indices.
  - CT uses indices 1..N/MIN_LEN-1, ascending.
  - GS uses indices N/MIN_LEN-1..1, descending.
- last_o=1 only alongside the final pair, while valid_o=1.
- start_i while busy_o=1 is ignored; mode_ct_i changes mid-transform are ignored.
- ready_i may toggle on any cycle, including the last pair of a stage; the drain starts only after that pair's handshake.

Optional Feature:
- Macro: NTT_PAIR_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles with valid_o=1 and ready_i=0 in the current transform.
  - Cleared on start, saturates at 16'hFFFF, held after done; reset to 0.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Test Plan:
- N=16, MIN_LEN=1, BU_LATENCY=3, CT, ready_i=1, start at cycle 0:
  - Stage 0: pairs (0,8)..(7,15) with zeta 1, valid_o in cycles 1-8.
  - Cycles 9-11: valid_o=0.
  - Stage 1: (0,4)..(3,7) zeta 2, then (8,12)..(11,15) zeta 3.
  - last_o on (14,15) zeta 15.
  - done_o in cycle 45.
- Same configuration, GS:
  - First pairs (0,1) z15, (2,3) z14 ... (14,15) z8.
  - Stage 1 starts with (0,2),(1,3) z7.
  - Final stage (0,8)..(7,15) z1; done_o in cycle 45.
- CT, ready_i held 0 for cycles 3-6:
  - addr_u_o=2, addr_t_o=10 stay stable.
  - Sequence resumes unchanged; done_o in cycle 49.
  - With the macro defined, stall_cnt_o=4.
- rst_i asserted in cycle 20 of a CT run:
  - Next cycle: IDLE, valid_o=0, busy_o=0, no done_o.
  - A new start produces (0,8) z1 again.
- N=256, MIN_LEN=2, BU_LATENCY=0, CT:
  - 7 stages, 896 handshakes, no valid gaps.
  - Max zeta_idx_o=127.
  - start_i pulsed mid-run is ignored; done_o once.
